heat_vga_render: RTL and testbench
==================================

HEAT_VGA_RENDER -- requirements
Module: heat_vga_render

Interface
REQ-001 SHALL have parameters H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48, giving horizontal front porch, sync and back porch in clocks.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, giving vertical visible lines, front porch, sync and back porch in lines.
REQ-004 SHALL use clock clk; reset rst_n, synchronous, active-low.
REQ-005 clk  input  1  pixel clock (25.175 MHz nominal).
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 cell_addr  output  6  grid read address, row-major: row in [5:3], column in [2:0].
REQ-008 cell_data  input  4  temperature at cell_addr; combinational read, valid in the same cycle.
REQ-009 hl_en  input  1  enables the cursor outline.
REQ-010 hl_addr  input  6  cell to outline.
REQ-011 hsync, vsync  output  1 each  sync outputs, active-low.
REQ-012 r, g, b  output  2 each  RGB222 colour.
REQ-013 de  output  1  high during the active area.
REQ-014 frame_start  output  1  one-clock pulse at pixel (0,0).

Function
REQ-015 SHALL keep hc counting 0..H_total-1, where H_total = 800 at defaults; hc wraps to 0 and advances vc.
REQ-016 SHALL keep vc counting 0..V_total-1, where V_total = 525; vc wraps to 0 when hc wraps on the last line.
REQ-017 Active area SHALL be hc < H_ACTIVE and vc < V_ACTIVE.
REQ-018 hsync SHALL be low for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
REQ-019 vsync SHALL be low for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
REQ-020 Grid region SHALL be hc 64..575 and vc 0..479; column = (hc-64)>>6; cell width 64 pixels.
REQ-021 Cell height SHALL be 60 lines. Row SHALL be tracked by a line-in-cell sub-counter (0..59) plus a row counter (0..7).
REQ-022 Both row counters SHALL clear at vc wrap; no divider is permitted.
REQ-023 cell_addr SHALL be {row, column} combinationally from the current counters inside the grid region, and 0 elsewhere.
REQ-024 Palette for temperature t: R = t[3:2]; G = t[1:0] when t[3]^t[2] is 1, else 0; B = 3 - t[3:2].
REQ-025 Highlight: white (r=g=b=3) when hl_en=1, current cell == hl_addr, and local x is 0 or 63 or local y is 0 or 59. Highlight overrides the palette.
REQ-026 Active area outside the grid SHALL be border grey (r=g=b=1).
REQ-027 Blanking SHALL drive rgb = 0.
REQ-028 All outputs SHALL be registered with exactly 1 clock latency from the counter value. hsync, vsync, de, rgb and frame_start SHALL stay mutually aligned.
REQ-029 frame_start SHALL be high for exactly one clock per frame: the clock in which the outputs reflect hc=0, vc=0.
REQ-030 hl_addr and hl_en SHALL be sampled every clock with no latching; a change takes effect on the next registered pixel.
REQ-031 cell_data changing mid-frame (grid update) SHALL be displayed immediately. No tearing protection is provided.

Reset
REQ-032 While rst_n=0 at a clk edge: hc=0, vc=0, row counters 0.
REQ-033 While rst_n=0 at a clk edge: hsync=1, vsync=1, rgb=0, de=0, frame_start=0.
REQ-034 On the first clock after rst_n rises, the outputs SHALL reflect pixel (0,0), with frame_start=1.
REQ-035 Reset asserted mid-frame SHALL abandon the frame, with no partial sync pulse beyond the reset edge.

Verification
REQ-036 Release reset -> frame_start=1 on the 1st cycle. hsync falls 656 clocks after frame_start, stays low 96 clocks, period 800 clocks. vsync is low for lines 490-491. Next frame_start comes 420000 clocks later.
REQ-037 Grid model returns t = cell_addr[3:0]. Pixel (64,0) -> cell_addr 0. Pixel (128,60) -> cell_addr 9. Pixel (575,479) -> cell_addr 63. Pixel (63,0) -> grey 1/1/1.
REQ-038 Palette sweep in the grid: t=0 -> r0 g0 b3; t=6 -> r1 g2 b2; t=9 -> r2 g1 b1; t=15 -> r3 g0 b0. Blanking pixels (hc>=640) -> rgb 0, de=0.
REQ-039 hl_en=1, hl_addr=9 -> white at pixels (128,60), (191,100), (150,119). Pixel (150,100) shows the palette colour. hl_en=0 -> no white anywhere.
REQ-040 Reset at pixel (300,200) for 3 clocks -> outputs idle per REQ-033. On release, frame_start=1 and counting restarts at (0,0).

Source files
------------

// File: rtl/heat_vga_render.sv
// heat_vga_render: VGA timing generator and renderer for an 8x8 heat-map grid.
//
// Produces VGA sync/blanking from a pixel counter pair (hc, vc). It draws an 8x8 grid of
// 64x60-pixel cells starting at hc=64, colouring each cell from a 4-bit temperature
// read combinationally from an external grid memory. It can also draw a white outline
// around one selected cell. Active pixels outside the grid are border grey; blanking is
// black. All outputs are registered one clock after the counter value they represent.
//
// Ports:
//   clk            pixel clock
//   rst_n          synchronous active-low reset
//   cell_addr_o    grid read address {row[2:0], col[2:0]}, 0 outside the grid
//   cell_data_i    temperature at cell_addr_o, valid in the same cycle
//   hl_en_i        enables the cursor outline
//   hl_addr_i      cell to outline
//   hsync_o        horizontal sync, active-low
//   vsync_o        vertical sync, active-low
//   r_o, g_o, b_o  RGB222 colour
//   de_o           high during the active area
//   frame_start_o  one-clock pulse on the output cycle for pixel (0,0)
module heat_vga_render #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [5:0] cell_addr_o,
    input  logic [3:0] cell_data_i,
    input  logic       hl_en_i,
    input  logic [5:0] hl_addr_i,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic [1:0] r_o,
    output logic [1:0] g_o,
    output logic [1:0] b_o,
    output logic       de_o,
    output logic       frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam int GRID_X0   = 64;
    localparam int CELL_W    = 64;
    localparam int CELL_H    = 60;
    localparam int GRID_COLS = 8;
    localparam int GRID_ROWS = 8;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [5:0]    LINE_LAST = 6'(CELL_H - 1);

    // Counters and row tracking
    logic [HW-1:0] hc_q, hc_d;
    logic [VW-1:0] vc_q, vc_d;
    logic [5:0]    line_q, line_d;  // line within the current cell row, 0..59
    logic [2:0]    row_q, row_d;

    // Registered outputs
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       de_q, de_d;
    logic       fs_q, fs_d;
    logic [1:0] r_q, r_d;
    logic [1:0] g_q, g_d;
    logic [1:0] b_q, b_d;

    // Pixel decode
    logic [15:0] hx, vy;
    logic [8:0]  gx;
    logic [2:0]  col;
    logic [5:0]  lx;
    logic        active;
    logic        in_grid;
    logic        hl_hit;
    logic [1:0]  pal_r, pal_g, pal_b;

    always_comb begin
        hc_d   = hc_q + HW'(1);
        vc_d   = vc_q;
        line_d = line_q;
        row_d  = row_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            if (vc_q == V_LAST) begin
                vc_d   = '0;
                line_d = '0;
                row_d  = '0;
            end else begin
                vc_d = vc_q + VW'(1);
                // Row advances every CELL_H lines; it wraps past the grid and is
                // ignored there, then cleared at the frame wrap.
                if (line_q == LINE_LAST) begin
                    line_d = '0;
                    row_d  = row_q + 3'd1;
                end else begin
                    line_d = line_q + 6'd1;
                end
            end
        end
    end

    // Widened copies so grid/sync constants compare correctly at any counter width
    assign hx = 16'(hc_q);
    assign vy = 16'(vc_q);
    assign gx = 9'(hx - 16'(GRID_X0));
    assign col = gx[8:6];
    assign lx  = gx[5:0];

    assign active  = (hx < 16'(H_ACTIVE)) && (vy < 16'(V_ACTIVE));
    assign in_grid = active && (hx >= 16'(GRID_X0))
                     && (hx < 16'(GRID_X0 + GRID_COLS * CELL_W))
                     && (vy < 16'(GRID_ROWS * CELL_H));

    assign cell_addr_o = in_grid ? {row_q, col} : 6'd0;

    assign pal_r = cell_data_i[3:2];
    assign pal_g = (cell_data_i[3] ^ cell_data_i[2]) ? cell_data_i[1:0] : 2'd0;
    assign pal_b = 2'd3 - cell_data_i[3:2];

    assign hl_hit = hl_en_i && in_grid && (cell_addr_o == hl_addr_i)
                    && ((lx == 6'd0) || (lx == 6'(CELL_W - 1))
                        || (line_q == 6'd0) || (line_q == LINE_LAST));

    always_comb begin
        hsync_d = !((hx >= 16'(H_ACTIVE + H_FP)) && (hx < 16'(H_ACTIVE + H_FP + H_SYNC)));
        vsync_d = !((vy >= 16'(V_ACTIVE + V_FP)) && (vy < 16'(V_ACTIVE + V_FP + V_SYNC)));
        de_d    = active;
        fs_d    = (hc_q == '0) && (vc_q == '0);
        r_d     = 2'd0;
        g_d     = 2'd0;
        b_d     = 2'd0;
        if (active) begin
            if (hl_hit) begin
                r_d = 2'd3;
                g_d = 2'd3;
                b_d = 2'd3;
            end else if (in_grid) begin
                r_d = pal_r;
                g_d = pal_g;
                b_d = pal_b;
            end else begin
                r_d = 2'd1;
                g_d = 2'd1;
                b_d = 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hc_q    <= '0;
            vc_q    <= '0;
            line_q  <= '0;
            row_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            r_q     <= 2'd0;
            g_q     <= 2'd0;
            b_q     <= 2'd0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            line_q  <= line_d;
            row_q   <= row_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            fs_q    <= fs_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign frame_start_o = fs_q;
    assign r_o           = r_q;
    assign g_o           = g_q;
    assign b_o           = b_q;

endmodule

// File: tb/tb_heat_vga_render.sv
// Testbench for heat_vga_render. Uses shortened porches and a 120-line active area so a
// full frame fits the simulation budget; the grid geometry (64x60 cells at hc=64) is fixed.
module tb_heat_vga_render;

    localparam int H_ACTIVE = 576;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 4;
    localparam int H_BP     = 2;
    localparam int V_ACTIVE = 120;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic       clk;
    logic       rst_n;
    logic [5:0] cell_addr;
    logic [3:0] cell_data;
    logic       hl_en;
    logic [5:0] hl_addr;
    logic       hsync, vsync, de, frame_start;
    logic [1:0] r, g, b;
    logic       flip;

    // Grid memory model: t = address, optionally inverted to emulate a live update
    assign cell_data = cell_addr[3:0] ^ {4{flip}};

    heat_vga_render #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cell_addr_o  (cell_addr),
        .cell_data_i  (cell_data),
        .hl_en_i      (hl_en),
        .hl_addr_i    (hl_addr),
        .hsync_o      (hsync),
        .vsync_o      (vsync),
        .r_o          (r),
        .g_o          (g),
        .b_o          (b),
        .de_o         (de),
        .frame_start_o(frame_start)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    typedef struct {
        int         x;
        int         y;
        logic [9:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  errors = 0;
    int  checks = 0;
    int  mx, my;   // pixel the DUT counters currently hold
    int  cyc;      // ticks since the last reset release

    // Reference pixel: {hsync, vsync, de, frame_start, r, g, b}
    function automatic logic [9:0] model_px(int x, int y, logic hle, logic [5:0] hla,
                                            logic fl);
        logic       hs, vs, den, fs;
        logic [1:0] pr, pg, pb;
        int         addr, t, lx, ly;
        hs  = !(x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC);
        vs  = !(y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC);
        den = (x < H_ACTIVE) && (y < V_ACTIVE);
        fs  = (x == 0) && (y == 0);
        pr  = 2'd0;
        pg  = 2'd0;
        pb  = 2'd0;
        if (den) begin
            if (x >= 64 && x < 576 && y < 480) begin
                addr = (y / 60) * 8 + (x - 64) / 64;
                lx   = (x - 64) % 64;
                ly   = y % 60;
                t    = (addr % 16) ^ (fl ? 15 : 0);
                if (hle && addr == int'(hla) && (lx == 0 || lx == 63 || ly == 0 || ly == 59)) begin
                    pr = 2'd3; pg = 2'd3; pb = 2'd3;
                end else begin
                    pr = 2'(t / 4);
                    pg = ((t / 4) == 1 || (t / 4) == 2) ? 2'(t % 4) : 2'd0;
                    pb = 2'(3 - t / 4);
                end
            end else begin
                pr = 2'd1; pg = 2'd1; pb = 2'd1;
            end
        end
        return {hs, vs, den, fs, pr, pg, pb};
    endfunction

    // Push the expectation for the current pixel, then clock once and advance the model
    task automatic tick();
        sb_t e;
        e.x   = mx;
        e.y   = my;
        e.exp = model_px(mx, my, hl_en, hl_addr, flip);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        mx++;
        if (mx == HT) begin
            mx = 0;
            my++;
            if (my == VT) my = 0;
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        hl_en   = 1'b0;
        hl_addr = 6'd0;
        flip    = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            checks++;
            if ({hsync, vsync, de, frame_start, r, g, b} !== 10'b1100000000) begin
                errors++;
                $display("FAIL reset_idle: got %b expected %b",
                         {hsync, vsync, de, frame_start, r, g, b}, 10'b1100000000);
            end
        end
        checks++;
        if (cell_addr !== 6'd0) begin
            errors++;
            $display("FAIL reset_addr: got %0d expected 0", cell_addr);
        end
        rst_n = 1'b1;
        mx    = 0;
        my    = 0;
        cyc   = 0;
        sb_q.delete();
    endtask

    task automatic test_timing();
        sb_t        e;
        logic [9:0] got;
        logic       prev_hs;
        int         fall1, fall2, rise1;
        prev_hs = 1'b1;
        fall1   = -1;
        fall2   = -1;
        rise1   = -1;
        for (int k = 0; k < 2 * HT; k++) begin
            if (mx == 64 && my == 0) begin
                checks++;
                if (cell_addr !== 6'd0) begin
                    errors++;
                    $display("FAIL addr_64_0: got %0d expected 0", cell_addr);
                end
            end
            if (mx == 128 && my == 0) begin
                checks++;
                if (cell_addr !== 6'd1) begin
                    errors++;
                    $display("FAIL addr_128_0: got %0d expected 1", cell_addr);
                end
            end
            tick();
            e   = sb_q.pop_front();
            got = {hsync, vsync, de, frame_start, r, g, b};
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL pixel (%0d,%0d): got %b expected %b", e.x, e.y, got, e.exp);
            end
            if (k == 0) begin
                checks++;
                if (frame_start !== 1'b1) begin
                    errors++;
                    $display("FAIL first_frame_start: got %b expected 1", frame_start);
                end
            end
            if (e.x == 63 && e.y == 0) begin
                checks++;
                if ({r, g, b} !== 6'b010101) begin
                    errors++;
                    $display("FAIL grey_63_0: got %b expected 010101", {r, g, b});
                end
            end
            if (e.x == H_ACTIVE + 1 && e.y == 0) begin
                checks++;
                if ({de, r, g, b} !== 7'b0) begin
                    errors++;
                    $display("FAIL blank_px: got %b expected 0000000", {de, r, g, b});
                end
            end
            if (prev_hs && !hsync) begin
                if (fall1 < 0) fall1 = k;
                else if (fall2 < 0) fall2 = k;
            end
            if (!prev_hs && hsync && rise1 < 0) rise1 = k;
            prev_hs = hsync;
        end
        checks++;
        if (fall1 != H_ACTIVE + H_FP) begin
            errors++;
            $display("FAIL hsync_fall: got %0d expected %0d", fall1, H_ACTIVE + H_FP);
        end
        checks++;
        if (rise1 - fall1 != H_SYNC) begin
            errors++;
            $display("FAIL hsync_width: got %0d expected %0d", rise1 - fall1, H_SYNC);
        end
        checks++;
        if (fall2 - fall1 != HT) begin
            errors++;
            $display("FAIL hsync_period: got %0d expected %0d", fall2 - fall1, HT);
        end
    endtask

    task automatic test_palette();
        sb_t        e;
        logic [9:0] got;
        hl_en = 1'b0;
        while (!(mx == 0 && my == 60)) begin
            tick();
            e   = sb_q.pop_front();
            got = {hsync, vsync, de, frame_start, r, g, b};
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL pixel (%0d,%0d): got %b expected %b", e.x, e.y, got, e.exp);
            end
            if (e.x == 100 && e.y == 30) begin
                checks++;
                if ({r, g, b} !== 6'b000011) begin
                    errors++;
                    $display("FAIL palette_t0: got %b expected 000011", {r, g, b});
                end
            end
            if (e.x == 480 && e.y == 30) begin
                checks++;
                if ({r, g, b} !== 6'b011010) begin
                    errors++;
                    $display("FAIL palette_t6: got %b expected 011010", {r, g, b});
                end
            end
        end
    endtask

    task automatic test_highlight();
        sb_t        e;
        logic [9:0] got;
        hl_addr = 6'd9;
        while (!(mx == 0 && my == 120)) begin
            // Lines 61-62 toggle the enable per clock; the scoreboard tracks each pixel
            hl_en = (my == 61 || my == 62) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mx == 128 && my == 60) begin
                checks++;
                if (cell_addr !== 6'd9) begin
                    errors++;
                    $display("FAIL addr_128_60: got %0d expected 9", cell_addr);
                end
            end
            if (mx == 575 && my == 119) begin
                checks++;
                if (cell_addr !== 6'd15) begin
                    errors++;
                    $display("FAIL addr_575_119: got %0d expected 15", cell_addr);
                end
            end
            tick();
            e   = sb_q.pop_front();
            got = {hsync, vsync, de, frame_start, r, g, b};
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL pixel (%0d,%0d): got %b expected %b", e.x, e.y, got, e.exp);
            end
            if ((e.x == 128 && e.y == 60) || (e.x == 191 && e.y == 100)
                || (e.x == 150 && e.y == 119)) begin
                checks++;
                if ({r, g, b} !== 6'b111111) begin
                    errors++;
                    $display("FAIL outline (%0d,%0d): got %b expected 111111",
                             e.x, e.y, {r, g, b});
                end
            end
            if (e.x == 150 && e.y == 100) begin
                checks++;
                if ({r, g, b} !== 6'b100101) begin
                    errors++;
                    $display("FAIL palette_t9: got %b expected 100101", {r, g, b});
                end
            end
            if (e.x == 540 && e.y == 80) begin
                checks++;
                if ({r, g, b} !== 6'b110000) begin
                    errors++;
                    $display("FAIL palette_t15: got %b expected 110000", {r, g, b});
                end
            end
        end
    endtask

    task automatic test_vsync_frame();
        sb_t        e;
        logic [9:0] got;
        int         vs_first, vs_last, n;
        logic       done;
        hl_en    = 1'b0;
        vs_first = -1;
        vs_last  = -1;
        done     = 1'b0;
        n        = 0;
        while (!done && n < HT * VT) begin
            tick();
            n++;
            e   = sb_q.pop_front();
            got = {hsync, vsync, de, frame_start, r, g, b};
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL pixel (%0d,%0d): got %b expected %b", e.x, e.y, got, e.exp);
            end
            if (!vsync) begin
                if (vs_first < 0) vs_first = e.y;
                vs_last = e.y;
            end
            if (e.x == 0 && e.y == 0) begin
                done = 1'b1;
                checks++;
                if (frame_start !== 1'b1 || cyc - 1 != HT * VT) begin
                    errors++;
                    $display("FAIL frame_period: got fs=%b after %0d expected fs=1 after %0d",
                             frame_start, cyc - 1, HT * VT);
                end
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL frame_wrap_timeout: got no wrap expected wrap within %0d", HT * VT);
        end
        checks++;
        if (vs_first != V_ACTIVE + V_FP || vs_last != V_ACTIVE + V_FP + V_SYNC - 1) begin
            errors++;
            $display("FAIL vsync_lines: got %0d..%0d expected %0d..%0d", vs_first, vs_last,
                     V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC - 1);
        end
    endtask

    task automatic test_no_highlight_update();
        sb_t        e;
        logic [9:0] got;
        hl_en   = 1'b0;
        hl_addr = 6'd0;
        flip    = 1'b1;
        while (!(mx == H_ACTIVE + H_FP + 2 && my == 10)) begin
            tick();
            e   = sb_q.pop_front();
            got = {hsync, vsync, de, frame_start, r, g, b};
            checks++;
            if (got !== e.exp || {r, g, b} === 6'b111111) begin
                errors++;
                $display("FAIL pixel_nohl (%0d,%0d): got %b expected %b", e.x, e.y, got, e.exp);
            end
            if (e.x == 100 && e.y == 5) begin
                checks++;
                if ({r, g, b} !== 6'b110000) begin
                    errors++;
                    $display("FAIL live_update: got %b expected 110000", {r, g, b});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        sb_t        e;
        logic [9:0] got;
        // Counters sit inside the hsync pulse here; reset must cut it off at once
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if ({hsync, vsync, de, frame_start, r, g, b} !== 10'b1100000000
                || cell_addr !== 6'd0) begin
                errors++;
                $display("FAIL midframe_reset: got %b addr %0d expected 1100000000 addr 0",
                         {hsync, vsync, de, frame_start, r, g, b}, cell_addr);
            end
        end
        rst_n = 1'b1;
        flip  = 1'b0;
        mx    = 0;
        my    = 0;
        cyc   = 0;
        sb_q.delete();
        for (int k = 0; k < 2 * HT; k++) begin
            tick();
            e   = sb_q.pop_front();
            got = {hsync, vsync, de, frame_start, r, g, b};
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL restart (%0d,%0d): got %b expected %b", e.x, e.y, got, e.exp);
            end
        end
    endtask

    initial begin
        #6_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_timing();
        test_palette();
        test_highlight();
        test_vsync_frame();
        test_no_highlight_update();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
